// File: rtl/tri_synth_pkg.sv
// Shared constants for the triangle-synth voice path: generator period width,
// default triangle width and the scheduler FSM encodings.
package tri_synth_pkg;

  localparam int PERIOD_W  = 8;
  localparam int DEF_TRI_W = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/tri_voice_scheduler_if.sv
// Scheduler bus: frame request, voice config, generator drive/return, mixed sample out.
// Build option TRI_SCHED_OVERRUN_CNT_EN adds the overrun_cnt status signal.
interface tri_voice_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int TRI_W      = tri_synth_pkg::DEF_TRI_W
) ();

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int MIX_W  = TRI_W + $clog2(NUM_VOICES);

  logic                              sample_tick;
  logic [NUM_VOICES-1:0]             voice_en;
  logic                              cfg_we;
  logic [VIDX_W-1:0]                 cfg_voice;
  logic [PHASE_W-1:0]                cfg_tune;
  logic [tri_synth_pkg::PERIOD_W-1:0] tri_period;
  logic [TRI_W-1:0]                  tri_value;
  logic [MIX_W-1:0]                  mix_out;
  logic                              mix_valid;
  logic                              busy;
`ifdef TRI_SCHED_OVERRUN_CNT_EN
  logic [7:0]                        overrun_cnt;
`endif

  modport master (
    output sample_tick, voice_en, cfg_we, cfg_voice, cfg_tune, tri_value,
    input  tri_period, mix_out, mix_valid, busy
`ifdef TRI_SCHED_OVERRUN_CNT_EN
    , input overrun_cnt
`endif
  );

  modport slave (
    input  sample_tick, voice_en, cfg_we, cfg_voice, cfg_tune, tri_value,
    output tri_period, mix_out, mix_valid, busy
`ifdef TRI_SCHED_OVERRUN_CNT_EN
    , output overrun_cnt
`endif
  );

endinterface

// File: rtl/tri_voice_scheduler.sv
// Time-shares one triangle generator across NUM_VOICES voices; tick -> mix_valid in 2*NUM_VOICES+1 cycles.
// Ticks arriving while busy are dropped (counted in overrun_cnt when TRI_SCHED_OVERRUN_CNT_EN is defined).
module tri_voice_scheduler
  import tri_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int TRI_W      = DEF_TRI_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tri_voice_scheduler_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int MIX_W = TRI_W + $clog2(NUM_VOICES);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MIX_W-1:0]    acc_q, acc_d;
  logic [MIX_W-1:0]    mix_out_q, mix_out_d;
  logic                mix_valid_q, mix_valid_d;
  logic [PERIOD_W-1:0] tri_period_q, tri_period_d;
  logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]  tune_q  [NUM_VOICES];
  logic                busy;
  logic                phase_adv;

  assign busy      = (state_q != ST_IDLE);
  assign phase_adv = (state_q == ST_ACC) && bus.voice_en[idx_q];

  // mix_out/mix_valid are loaded on the last ACC edge so both are valid during DONE
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    mix_out_d    = mix_out_q;
    mix_valid_d  = 1'b0;
    tri_period_d = tri_period_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_tick) state_d = ST_SEL;
      end
      ST_SEL: begin
        tri_period_d = phase_q[idx_q][PHASE_W-1 -: PERIOD_W];
        state_d      = ST_ACC;
      end
      ST_ACC: begin
        if (bus.voice_en[idx_q]) acc_d = acc_q + MIX_W'(bus.tri_value);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          mix_out_d   = acc_d;
          mix_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SEL;
        end
      end
      ST_DONE: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
      tri_period_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      mix_out_q    <= mix_out_d;
      mix_valid_q  <= mix_valid_d;
      tri_period_q <= tri_period_d;
    end
  end

  // Phase reads tune_q, so a tune write landing on the same ACC cycle takes effect next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        phase_q[k] <= '0;
        tune_q[k]  <= '0;
      end
    end else begin
      if (phase_adv) phase_q[idx_q] <= phase_q[idx_q] + tune_q[idx_q];
      if (bus.cfg_we) tune_q[bus.cfg_voice] <= bus.cfg_tune;
    end
  end

`ifdef TRI_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else if (bus.sample_tick && busy && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bus.overrun_cnt = overrun_q;
`endif

  assign bus.tri_period = tri_period_q;
  assign bus.mix_out    = mix_out_q;
  assign bus.mix_valid  = mix_valid_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_tri_voice_scheduler.sv
// Bench for tri_voice_scheduler with a stand-in generator tri_value = 7*period + 3.
// Build option TRI_SCHED_OVERRUN_CNT_EN enables the overrun_cnt checks.
module tb_tri_voice_scheduler;

  localparam int NV    = 4;
  localparam int PW    = 16;
  localparam int TW    = 11;
  localparam int MW    = TW + $clog2(NV);

  typedef struct {
    logic [MW-1:0] mix;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  tri_voice_scheduler_if #(.NUM_VOICES(NV), .PHASE_W(PW), .TRI_W(TW)) bus_if ();

  tri_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW), .TRI_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic logic [TW-1:0] gen(input logic [7:0] p);
    return TW'(p) * TW'(7) + TW'(3);
  endfunction

  assign bus_if.tri_value = gen(bus_if.tri_period);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int v, input logic [PW-1:0] t);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_voice = 2'(v);
    bus_if.cfg_tune  = t;
    step(1);
    bus_if.cfg_we    = 1'b0;
  endtask

  task automatic expect_frame(input int mix);
    sb.push_back('{MW'(mix), cyc + 9});
  endtask

  task automatic frame(input int mix);
    bus_if.sample_tick = 1'b1;
    expect_frame(mix);
    step(1);
    bus_if.sample_tick = 1'b0;
    chk("busy_in_frame", 32'(bus_if.busy), 32'd1);
    step(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Monitor: every mix_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus_if.mix_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_mix_valid: got mix_out %0d expected no pulse (cycle %0d)",
                 bus_if.mix_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mix_out", 32'(bus_if.mix_out), 32'(e.mix));
        chk("mix_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.sample_tick = 1'b0;
    bus_if.voice_en    = '0;
    bus_if.cfg_we      = 1'b0;
    bus_if.cfg_voice   = '0;
    bus_if.cfg_tune    = '0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("rst_tri_period", 32'(bus_if.tri_period), 32'd0);
    chk("rst_mix_out", 32'(bus_if.mix_out), 32'd0);
    chk("rst_mix_valid", 32'(bus_if.mix_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
`ifdef TRI_SCHED_OVERRUN_CNT_EN
    chk("rst_overrun_cnt", 32'(bus_if.overrun_cnt), 32'd0);
`endif

    // voice 0 stepping one period per frame: periods 0,1,2
    cfg(0, 16'h0100);
    bus_if.voice_en = 4'b0001;
    frame(3);
    frame(10);
    frame(17);

    // voice 1 tune 0xFFFF: phases 0000, FFFF, FFFE -> periods 00, FF, FF
    cfg(1, 16'hFFFF);
    bus_if.voice_en = 4'b0010;
    frame(3);
    frame(1788);
    frame(1788);

    // all voices, zero tune, from reset
    do_reset();
    bus_if.voice_en = 4'b1111;
    frame(12);
    frame(12);

    // second tick 3 cycles after the first is dropped
    bus_if.sample_tick = 1'b1;
    expect_frame(12);
    step(1);
    bus_if.sample_tick = 1'b0;
    step(2);
    bus_if.sample_tick = 1'b1;
    step(1);
    bus_if.sample_tick = 1'b0;
    step(8);
`ifdef TRI_SCHED_OVERRUN_CNT_EN
    chk("overrun_one", 32'(bus_if.overrun_cnt), 32'd1);
`endif

    // 40 frames with the tick held through 8 busy cycles each: 1 + 320 overruns
    repeat (40) begin
      bus_if.sample_tick = 1'b1;
      expect_frame(12);
      step(9);
      bus_if.sample_tick = 1'b0;
      step(2);
    end
`ifdef TRI_SCHED_OVERRUN_CNT_EN
    chk("overrun_sat", 32'(bus_if.overrun_cnt), 32'd255);
`endif

    // tune write landing on voice 2's ACC cycle: old step this frame, new step next
    do_reset();
    cfg(2, 16'h0100);
    bus_if.voice_en = 4'b0100;
    bus_if.sample_tick = 1'b1;
    expect_frame(3);
    step(1);
    bus_if.sample_tick = 1'b0;
    step(5);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_voice = 2'd2;
    bus_if.cfg_tune  = 16'h0400;
    step(1);
    bus_if.cfg_we    = 1'b0;
    step(4);
    frame(10);
    frame(38);

    // reset during voice 2's ACC cycle (phase 0x0900): everything clears, no pulse
    bus_if.sample_tick = 1'b1;
    step(1);
    bus_if.sample_tick = 1'b0;
    step(5);
    chk("pre_abort_tri_period", 32'(bus_if.tri_period), 32'd9);
    chk("pre_abort_mix_out", 32'(bus_if.mix_out), 32'd38);
    rst_n = 1'b0;
    #1;
    chk("abort_tri_period", 32'(bus_if.tri_period), 32'd0);
    chk("abort_mix_out", 32'(bus_if.mix_out), 32'd0);
    chk("abort_mix_valid", 32'(bus_if.mix_valid), 32'd0);
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(12);
    bus_if.voice_en = 4'b1111;
    frame(12);

    step(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
